// File: rtl/decode_exec_stage.sv
// decode_exec_stage: registered RV32 decode to exec params with a 2-entry skid buffer and valid/ready on both sides
module decode_exec_stage #(
  parameter int XLEN = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_exec_op,
  output logic [1:0]      out_op1_sel,
  output logic            out_op2_sel,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);
  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b10, FULL = 2'b11} state_t;
  typedef struct packed {
    logic [4:0]      op;
    logic [1:0]      op1;
    logic            op2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            ill;
  } ent_t;
  state_t state, next;
  ent_t d, m, s;
  logic [31:0] imm32;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic accept, drain, load_m, load_s, m_from_s;
  assign opc = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  always_comb begin
    d = '0;
    imm32 = '0;
    d.pc = in_pc;
    d.op2 = 1'b1;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'b0000001) begin
          d.op = ENABLE_M ? {2'b10, f3} : 5'h00;
          d.ill = !ENABLE_M;
          d.op2 = !ENABLE_M;
        end else begin
          d.op = {1'b0, f7[5], f3};
          d.op2 = 1'b0;
        end
      end
      7'b0010011: begin
        d.op = {1'b0, (f3 == 3'b101) & f7[5], f3};
        imm32 = (f3 == 3'b001 || f3 == 3'b101) ? {27'b0, in_instr[24:20]} : {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b0000011, 7'b1100111, 7'b1110011: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      7'b0100011: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      7'b1100011: begin
        d.op1 = 2'b01;
        imm32 = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      7'b1101111: begin
        d.op1 = 2'b01;
        imm32 = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      7'b0010111: begin
        d.op1 = 2'b01;
        imm32 = {in_instr[31:12], 12'b0};
      end
      7'b0110111: begin
        d.op1 = 2'b10;
        imm32 = {in_instr[31:12], 12'b0};
      end
      default: d.ill = 1'b1;
    endcase
    d.imm = XLEN'($signed(imm32));
  end
  assign out_valid = state[1];
  assign accept = in_valid & in_ready;
  assign drain = out_valid & out_ready;
  always_comb begin
    next = state;
    load_m = 1'b0;
    load_s = 1'b0;
    m_from_s = 1'b0;
    if (flush) next = EMPTY;
    else
      case (state)
        EMPTY: begin
          next = accept ? ONE : EMPTY;
          load_m = accept;
        end
        ONE: begin
          next = accept ? (drain ? ONE : FULL) : (drain ? EMPTY : ONE);
          load_m = accept & drain;
          load_s = accept & !drain;
        end
        FULL: begin
          next = drain ? ONE : FULL;
          load_m = drain;
          m_from_s = drain;
        end
        default: next = EMPTY;
      endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      in_ready <= 1'b1;
      m <= '0;
      s <= '0;
    end else begin
      state <= next;
      in_ready <= next != FULL;
      if (load_m) m <= m_from_s ? s : d;
      if (load_s) s <= d;
    end
  end
  assign out_exec_op = m.op;
  assign out_op1_sel = m.op1;
  assign out_op2_sel = m.op2;
  assign out_imm = m.imm;
  assign out_pc = m.pc;
  assign out_illegal = m.ill;
endmodule

// File: tb/tb_decode_exec_stage.sv
// tb_decode_exec_stage: directed checks of decode, skid buffering, flush and reset
module tb_decode_exec_stage;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic [63:0] pc64;
  logic in_ready, out_valid, out_op2_sel, out_illegal;
  logic [4:0] out_exec_op;
  logic [1:0] out_op1_sel;
  logic [31:0] out_imm, out_pc;
  logic b_in_ready, b_out_valid, b_op2, b_ill;
  logic [4:0] b_op;
  logic [1:0] b_op1;
  logic [63:0] b_imm, b_pc;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign pc64 = {32'b0, in_pc};
  decode_exec_stage #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_exec_op(out_exec_op), .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
    .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal));
  decode_exec_stage #(.XLEN(64), .ENABLE_M(1'b0)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(pc64), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_exec_op(b_op), .out_op1_sel(b_op1), .out_op2_sel(b_op2),
    .out_imm(b_imm), .out_pc(b_pc), .out_illegal(b_ill));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc = pc;
    step();
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_op", out_exec_op, 0);
    chk("rst_sel1", out_op1_sel, 0);
    chk("rst_sel2", out_op2_sel, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_ill", out_illegal, 0);
    out_ready = 1'b1;
    offer(32'h003100B3, 32'h0);
    chk("add_valid", out_valid, 1);
    chk("add_op", out_exec_op, 5'h00);
    chk("add_sel1", out_op1_sel, 2'b00);
    chk("add_sel2", out_op2_sel, 0);
    chk("add_imm", out_imm, 0);
    offer(32'h403100B3, 32'h4);
    chk("sub_op", out_exec_op, 5'h08);
    chk("sub_pc", out_pc, 32'h4);
    offer(32'h40315093, 32'h8);
    chk("srai_op", out_exec_op, 5'h0D);
    chk("srai_sel1", out_op1_sel, 2'b00);
    chk("srai_sel2", out_op2_sel, 1);
    chk("srai_imm", out_imm, 3);
    offer(32'h023100B3, 32'hC);
    chk("mul_op_m1", out_exec_op, 5'h10);
    chk("mul_ill_m1", out_illegal, 0);
    chk("mul_op_m0", b_op, 5'h00);
    chk("mul_ill_m0", b_ill, 1);
    offer(32'h12345097, 32'h100);
    chk("auipc_sel1", out_op1_sel, 2'b01);
    chk("auipc_sel2", out_op2_sel, 1);
    chk("auipc_imm", out_imm, 32'h12345000);
    chk("auipc_pc", out_pc, 32'h100);
    chk("auipc_pc64", b_pc, 64'h100);
    offer(32'hFE000EE3, 32'h104);
    chk("beq_imm", out_imm, 32'hFFFFFFFC);
    chk("beq_imm64", b_imm, 64'hFFFFFFFFFFFFFFFC);
    chk("beq_sel1", out_op1_sel, 2'b01);
    offer(32'h00000000, 32'h108);
    chk("bad_ill", out_illegal, 1);
    chk("bad_op", out_exec_op, 0);
    chk("bad_valid", out_valid, 1);
    in_valid = 1'b0;
    step();
    chk("drain_empty", out_valid, 0);
    out_ready = 1'b0;
    offer(32'h003100B3, 32'h200);
    chk("st1_valid", out_valid, 1);
    chk("st1_ready", in_ready, 1);
    offer(32'h403100B3, 32'h204);
    chk("st2_ready", in_ready, 0);
    chk("st2_op", out_exec_op, 5'h00);
    offer(32'h40315093, 32'h208);
    chk("st3_ready", in_ready, 0);
    chk("st3_pc", out_pc, 32'h200);
    chk("st3_op", out_exec_op, 5'h00);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("rel1_op", out_exec_op, 5'h08);
    chk("rel1_pc", out_pc, 32'h204);
    chk("rel1_valid", out_valid, 1);
    chk("rel1_ready", in_ready, 1);
    step();
    chk("rel2_valid", out_valid, 0);
    out_ready = 1'b0;
    offer(32'h003100B3, 32'h300);
    offer(32'h403100B3, 32'h304);
    chk("fl_full", in_ready, 0);
    flush = 1'b1;
    offer(32'h12345097, 32'h308);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("fl_drop", out_valid, 0);
    out_ready = 1'b0;
    offer(32'h003100B3, 32'h400);
    offer(32'h403100B3, 32'h404);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rr_valid", out_valid, 0);
    chk("rr_ready", in_ready, 1);
    chk("rr_imm", out_imm, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
